// File: rtl/pair_triple_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : pair_triple_pattern_gen
// Brief    : Stimulus generator for the three-input pair/triple (2-of-3
//            majority) detector. One start command selects the class
//            (majority / minority) and the pattern count. Patterns are
//            emitted on in0..in2 over a valid/ready stream, followed by a
//            one-cycle done pulse.
// Options  : `define PAIR_TRIPLE_PATTERN_GEN_SHUFFLE_EN visits the pattern
//            table in bit-reversed index order (0,2,1,3) instead of 0,1,2,3.
// Revision : 1.0 - initial release
// ============================================================================
module pair_triple_pattern_gen #(
  parameter int p_nbits_count = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic [p_nbits_count-1:0] count,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic                     in0,
  output logic                     in1,
  output logic                     in2,
  output logic                     busy,
  output logic                     done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_EMIT = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  // One extra bit so count=0 can represent the full 2^p_nbits_count run.
  localparam int                c_REM_W = p_nbits_count + 1;
  localparam logic [c_REM_W-1:0] c_FULL  = {1'b1, {p_nbits_count{1'b0}}};
  localparam logic [c_REM_W-1:0] c_ONE   = {{p_nbits_count{1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [1:0]         state_q,     state_d;
  logic               mode_q,      mode_d;
  logic [1:0]         index_q,     index_d;
  logic [c_REM_W-1:0] remaining_q, remaining_d;

  logic               w_fire;
  logic [1:0]         w_tbl_idx;
  logic [2:0]         w_pattern;

  // Pattern tables, bit order {in0,in1,in2}. Every majority entry has at
  // least two ones; every minority entry has at most one.
  function automatic logic [2:0] f_pattern(input logic m, input logic [1:0] idx);
    logic [2:0] p;
    p = 3'b000;
    if (m) begin
      case (idx)
        2'd0:    p = 3'b011;
        2'd1:    p = 3'b101;
        2'd2:    p = 3'b110;
        default: p = 3'b111;
      endcase
    end else begin
      case (idx)
        2'd0:    p = 3'b000;
        2'd1:    p = 3'b001;
        2'd2:    p = 3'b010;
        default: p = 3'b100;
      endcase
    end
    return p;
  endfunction

  // A transfer happens only while a pattern is actually on offer.
  assign w_fire = (state_q == c_EMIT) && out_rdy;

  // The index counter always steps 0,1,2,3; the shuffled order is obtained by
  // reading the table through the bit-reversed counter value.
`ifdef PAIR_TRIPLE_PATTERN_GEN_SHUFFLE_EN
  assign w_tbl_idx = {index_q[0], index_q[1]};
`else
  assign w_tbl_idx = index_q;
`endif

  assign w_pattern = f_pattern(mode_q, w_tbl_idx);

  // Next-state logic: command capture in IDLE, stepping on each handshake.
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    index_d     = index_q;
    remaining_d = remaining_q;
    case (state_q)
      c_IDLE: begin
        if (start) begin
          mode_d      = mode;
          index_d     = 2'd0;
          remaining_d = (count == '0) ? c_FULL : {1'b0, count};
          state_d     = c_EMIT;
        end
      end
      c_EMIT: begin
        if (w_fire) begin
          index_d     = index_q + 2'd1;
          remaining_d = remaining_q - c_ONE;
          if (remaining_q == c_ONE) begin
            state_d = c_DONE;
          end
        end
      end
      c_DONE: begin
        // Single-cycle completion; a start seen here is deliberately dropped.
        state_d = c_IDLE;
      end
      default: begin
        state_d = c_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that overrides any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= c_IDLE;
      mode_q      <= 1'b0;
      index_q     <= 2'd0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      index_q     <= index_d;
      remaining_q <= remaining_d;
    end
  end

  // Outputs decode purely from registered state, so they hold stable while
  // the consumer stalls and are forced to zero outside EMIT.
  always_comb begin
    out_val         = (state_q == c_EMIT);
    {in0, in1, in2} = out_val ? w_pattern : 3'b000;
    busy            = (state_q == c_EMIT) || (state_q == c_DONE);
    done            = (state_q == c_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_pair_triple_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pair_triple_pattern_gen
// Brief    : Self-checking bench for pair_triple_pattern_gen. Directed steps
//            followed by randomized commands/backpressure, checked against a
//            transaction-level reference model (patterns sent vs. total).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pair_triple_pattern_gen;

  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic [NB-1:0] count = '0;
  logic          out_rdy = 1'b0;
  logic          out_val, in0, in1, in2, busy, done;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: command-level view of the generator.
  logic m_active = 1'b0;   // a command is emitting patterns
  logic m_done   = 1'b0;   // done pulse is due this cycle
  logic m_mode   = 1'b0;
  int   m_total  = 0;
  int   m_sent   = 0;

  logic [2:0] maj_tbl [4];
  logic [2:0] min_tbl [4];
  int         order   [4];

  pair_triple_pattern_gen #(.p_nbits_count(NB)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mode    (mode),
    .count   (count),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .in0     (in0),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Behaviour of the downstream 2-of-3 detector.
  function automatic logic maj3(input logic [2:0] p);
    return (p[2] & p[1]) | (p[2] & p[0]) | (p[1] & p[0]);
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] exp_pat;
    logic [2:0] obs_pat;
    obs_pat = {in0, in1, in2};
    exp_pat = 3'b000;
    if (m_active)
      exp_pat = m_mode ? maj_tbl[order[m_sent % 4]] : min_tbl[order[m_sent % 4]];
    chk("out_val", {2'b00, out_val}, {2'b00, m_active});
    chk("pattern", obs_pat, exp_pat);
    chk("busy",    {2'b00, busy},    {2'b00, (m_active | m_done)});
    chk("done",    {2'b00, done},    {2'b00, m_done});
    if (m_active)
      chk("detector", {2'b00, maj3(obs_pat)}, {2'b00, m_mode});
  endtask

  // One clock: drive inputs on the falling edge, advance the model on the
  // rising edge using the same inputs, then compare just after the edge.
  task automatic step(input logic r, input logic s, input logic m,
                      input logic [NB-1:0] c, input logic rdy);
    @(negedge clk);
    rst = r; start = s; mode = m; count = c; out_rdy = rdy;
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
      m_done   = 1'b0;
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (m_active) begin
      if (rdy) begin
        m_sent++;
        if (m_sent == m_total) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (s) begin
      m_active = 1'b1;
      m_mode   = m;
      m_total  = (c == '0) ? (1 << NB) : int'(c);
      m_sent   = 0;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    maj_tbl[0] = 3'b011; maj_tbl[1] = 3'b101; maj_tbl[2] = 3'b110; maj_tbl[3] = 3'b111;
    min_tbl[0] = 3'b000; min_tbl[1] = 3'b001; min_tbl[2] = 3'b010; min_tbl[3] = 3'b100;
`ifdef PAIR_TRIPLE_PATTERN_GEN_SHUFFLE_EN
    order[0] = 0; order[1] = 2; order[2] = 1; order[3] = 3;
`else
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3;
`endif

    // Reset held with start asserted: nothing may be accepted.
    step(1'b1, 1'b1, 1'b1, 3'd4, 1'b1);
    step(1'b1, 1'b1, 1'b1, 3'd4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);

    // Basic majority run, consumer always ready.
    step(1'b0, 1'b1, 1'b1, 3'd4, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // count=0 minority: 8 patterns wrapping the table, then done.
    step(1'b0, 1'b1, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // Backpressure with a conflicting start during EMIT.
    step(1'b0, 1'b1, 1'b1, 3'd2, 1'b0);
    step(1'b0, 1'b1, 1'b0, 3'd7, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b1);   // start in DONE is dropped
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // Reset mid-command after the 2nd handshake, then a fresh 1-pattern run.
    step(1'b0, 1'b1, 1'b1, 3'd4, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 3'd1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);

    // Randomized commands, backpressure and occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 1)),
           NB'($urandom_range(0, (1 << NB) - 1)),
           ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
